mem_wb_stage: RTL and testbench

//  Pipeline stage directly downstream of the MEM stage. Registers MEM results into the WB slot and waits for load data from the data bus.

---
 rtl/mem_wb_stage_pkg.sv | 21 ++
 rtl/mem_wb_stage_load_align.sv | 32 +++
 rtl/mem_wb_stage.sv | 186 ++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: default widths, load-size encodings
// and the WB-slot state encoding.
package mem_wb_stage_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int CP0_ADDR_W_DEF = 8;
    localparam int WAIT_LIMIT_DEF = 255;

    localparam logic [3:0] MEM_SEL_BYTE = 4'b0001;
    localparam logic [3:0] MEM_SEL_HALF = 4'b0011;
    localparam logic [3:0] MEM_SEL_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } wb_state_e;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Extracts the addressed byte/half/word from a word-aligned read and
// sign- or zero-extends it to DATA_W bits.
module load_align
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        addr,
    input  logic [3:0]        sel,
    input  logic              sext,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{addr, 3'b000} +: 8];
        lane_h = rdata[{addr[1], 4'b0000} +: 16];
        data   = '0;
        case (sel)
            MEM_SEL_BYTE: data = sext ? {{(DATA_W-8){lane_b[7]}}, lane_b}
                                      : {{(DATA_W-8){1'b0}}, lane_b};
            MEM_SEL_HALF: data = sext ? {{(DATA_W-16){lane_h[15]}}, lane_h}
                                      : {{(DATA_W-16){1'b0}}, lane_h};
            MEM_SEL_WORD: data = rdata;
            default:      data = '0;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// WB slot: registers MEM results, waits for load data, and drives the GPR,
// HI/LO and CP0 write ports. Stalls the pipeline while a read is outstanding.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CP0_ADDR_W = CP0_ADDR_W_DEF,
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall_in,
    output logic                  stall_req,
    input  logic                  mem_read_in,
    input  logic                  mem_sext_in,
    input  logic [3:0]            mem_sel_in,
    input  logic [DATA_W-1:0]     result_in,
    input  logic                  wr_en_in,
    input  logic [REG_ADDR_W-1:0] wr_addr_in,
    input  logic                  hilo_en_in,
    input  logic [DATA_W-1:0]     hi_in,
    input  logic [DATA_W-1:0]     lo_in,
    input  logic                  cp0_en_in,
    input  logic [CP0_ADDR_W-1:0] cp0_addr_in,
    input  logic [DATA_W-1:0]     cp0_data_in,
    input  logic                  exc_null_in,
    input  logic [DATA_W-1:0]     ram_rdata,
    input  logic                  ram_rvalid,
    output logic                  reg_wr_en,
    output logic [REG_ADDR_W-1:0] reg_wr_addr,
    output logic [DATA_W-1:0]     reg_wr_data,
    output logic                  hilo_wr_en,
    output logic [DATA_W-1:0]     hi_out,
    output logic [DATA_W-1:0]     lo_out,
    output logic                  cp0_wr_en,
    output logic [CP0_ADDR_W-1:0] cp0_wr_addr,
    output logic [DATA_W-1:0]     cp0_wr_data,
    output logic                  bus_timeout,
    output wb_state_e             dbg_state
);

    localparam int              CNT_W   = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_LIMIT);

    // Handshake: the slot accepts a new instruction only on a cycle with
    // !flush && !stall_in && !stall_req; otherwise MEM must hold its outputs.
    logic                  s_load, s_sext;
    logic [3:0]            s_sel;
    logic [DATA_W-1:0]     s_result;
    logic                  s_wr_en;
    logic [REG_ADDR_W-1:0] s_wr_addr;
    logic                  s_hilo_en;
    logic [DATA_W-1:0]     s_hi, s_lo;
    logic                  s_cp0_en;
    logic [CP0_ADDR_W-1:0] s_cp0_addr;
    logic [DATA_W-1:0]     s_cp0_data;

    wb_state_e         state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [DATA_W-1:0] ld_data, ld_data_nx;
    logic              timeout_nx;
    logic [DATA_W-1:0] aligned;
    logic              capture, new_load;

    assign stall_req = (state == ST_WAIT) || (state == ST_DRAIN);
    assign capture   = !flush && !stall_in && !stall_req;
    assign new_load  = mem_read_in && exc_null_in;

    load_align #(.DATA_W(DATA_W)) u_align (
        .rdata (ram_rdata),
        .addr  (s_result[1:0]),
        .sel   (s_sel),
        .sext  (s_sext),
        .data  (aligned)
    );

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        ld_data_nx = ld_data;
        timeout_nx = 1'b0;
        case (state)
            ST_IDLE: begin
                if (capture && new_load) begin
                    state_nx = ST_WAIT;
                    cnt_nx   = '0;
                end
            end
            ST_WAIT: begin
                // A read returning alongside the flush leaves nothing to drain.
                if (flush) begin
                    state_nx = ram_rvalid ? ST_IDLE : ST_DRAIN;
                end else if (ram_rvalid) begin
                    ld_data_nx = aligned;
                    state_nx   = ST_DONE;
                end else if (cnt == CNT_MAX) begin
                    ld_data_nx = '0;
                    timeout_nx = 1'b1;
                    state_nx   = ST_DONE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (flush) begin
                    state_nx = ST_IDLE;
                end else if (capture) begin
                    state_nx = new_load ? ST_WAIT : ST_IDLE;
                    cnt_nx   = '0;
                end
            end
            ST_DRAIN: begin
                if (flush || ram_rvalid || cnt == CNT_MAX) begin
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ld_data     <= '0;
            bus_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            ld_data     <= ld_data_nx;
            bus_timeout <= timeout_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_load     <= 1'b0;
            s_sext     <= 1'b0;
            s_sel      <= '0;
            s_result   <= '0;
            s_wr_en    <= 1'b0;
            s_wr_addr  <= '0;
            s_hilo_en  <= 1'b0;
            s_hi       <= '0;
            s_lo       <= '0;
            s_cp0_en   <= 1'b0;
            s_cp0_addr <= '0;
            s_cp0_data <= '0;
        end else if (flush) begin
            s_load    <= 1'b0;
            s_wr_en   <= 1'b0;
            s_hilo_en <= 1'b0;
            s_cp0_en  <= 1'b0;
        end else if (capture) begin
            // An excepting instruction is kept as a bubble with no side effects.
            s_load     <= new_load;
            s_sext     <= mem_sext_in;
            s_sel      <= mem_sel_in;
            s_result   <= result_in;
            s_wr_en    <= wr_en_in && exc_null_in;
            s_wr_addr  <= wr_addr_in;
            s_hilo_en  <= hilo_en_in && exc_null_in;
            s_hi       <= hi_in;
            s_lo       <= lo_in;
            s_cp0_en   <= cp0_en_in && exc_null_in;
            s_cp0_addr <= cp0_addr_in;
            s_cp0_data <= cp0_data_in;
        end
    end

    assign reg_wr_en   = s_wr_en && (!s_load || state == ST_DONE);
    assign reg_wr_addr = s_wr_addr;
    assign reg_wr_data = s_load ? ld_data : s_result;
    assign hilo_wr_en  = s_hilo_en;
    assign hi_out      = s_hi;
    assign lo_out      = s_lo;
    assign cp0_wr_en   = s_cp0_en;
    assign cp0_wr_addr = s_cp0_addr;
    assign cp0_wr_data = s_cp0_data;
    assign dbg_state   = state;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: expected GPR writes are queued when an
// instruction is driven and popped when the write port asserts.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    localparam int DW  = 32;
    localparam int RW  = 5;
    localparam int CW  = 8;
    localparam int WL  = 255;
    localparam int SBW = RW + DW;

    logic          clk, rst, flush, stall_in, stall_req;
    logic          mem_read_in, mem_sext_in;
    logic [3:0]    mem_sel_in;
    logic [DW-1:0] result_in;
    logic          wr_en_in;
    logic [RW-1:0] wr_addr_in;
    logic          hilo_en_in;
    logic [DW-1:0] hi_in, lo_in;
    logic          cp0_en_in;
    logic [CW-1:0] cp0_addr_in;
    logic [DW-1:0] cp0_data_in;
    logic          exc_null_in;
    logic [DW-1:0] ram_rdata;
    logic          ram_rvalid;
    logic          reg_wr_en;
    logic [RW-1:0] reg_wr_addr;
    logic [DW-1:0] reg_wr_data;
    logic          hilo_wr_en;
    logic [DW-1:0] hi_out, lo_out;
    logic          cp0_wr_en;
    logic [CW-1:0] cp0_wr_addr;
    logic [DW-1:0] cp0_wr_data;
    logic          bus_timeout;
    wb_state_e     dbg_state;

    logic [SBW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_mis = 0;

    mem_wb_stage #(.DATA_W(DW), .REG_ADDR_W(RW), .CP0_ADDR_W(CW), .WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in), .stall_req(stall_req),
        .mem_read_in(mem_read_in), .mem_sext_in(mem_sext_in), .mem_sel_in(mem_sel_in),
        .result_in(result_in), .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in),
        .hilo_en_in(hilo_en_in), .hi_in(hi_in), .lo_in(lo_in),
        .cp0_en_in(cp0_en_in), .cp0_addr_in(cp0_addr_in), .cp0_data_in(cp0_data_in),
        .exc_null_in(exc_null_in), .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .hilo_wr_en(hilo_wr_en), .hi_out(hi_out), .lo_out(lo_out),
        .cp0_wr_en(cp0_wr_en), .cp0_wr_addr(cp0_wr_addr), .cp0_wr_data(cp0_wr_data),
        .bus_timeout(bus_timeout), .dbg_state(dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input wb_state_e exp);
        check(tag, DW'(dbg_state), DW'(exp));
    endtask

    // driver tasks
    task automatic idle_inputs();
        flush       = 1'b0;
        stall_in    = 1'b0;
        mem_read_in = 1'b0;
        mem_sext_in = 1'b0;
        mem_sel_in  = 4'b0000;
        result_in   = '0;
        wr_en_in    = 1'b0;
        wr_addr_in  = '0;
        hilo_en_in  = 1'b0;
        hi_in       = '0;
        lo_in       = '0;
        cp0_en_in   = 1'b0;
        cp0_addr_in = '0;
        cp0_data_in = '0;
        exc_null_in = 1'b1;
    endtask

    task automatic drive_alu(input logic [RW-1:0] a, input logic [DW-1:0] r);
        idle_inputs();
        wr_en_in   = 1'b1;
        wr_addr_in = a;
        result_in  = r;
        exp_q.push_back({a, r});
    endtask

    task automatic drive_load(input logic [RW-1:0] a, input logic [DW-1:0] ea,
                              input logic [3:0] sel, input logic sx);
        idle_inputs();
        mem_read_in = 1'b1;
        mem_sext_in = sx;
        mem_sel_in  = sel;
        result_in   = ea;
        wr_en_in    = 1'b1;
        wr_addr_in  = a;
    endtask

    // scoreboard pop: compare the GPR write port against the oldest expectation
    task automatic check_write(input string tag);
        logic [SBW-1:0] e;
        check({tag, "_qdepth"}, DW'(exp_q.size() > 0), DW'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_en"}, DW'(reg_wr_en), DW'(1));
            check({tag, "_addr"}, DW'(reg_wr_addr), DW'(e[SBW-1:DW]));
            check({tag, "_data"}, reg_wr_data, e[DW-1:0]);
        end
    endtask

    // Load already driven at this negedge; rvalid is returned in stall cycle 'delay'.
    task automatic run_load(input string tag, input int delay, input logic [DW-1:0] rd);
        int stalls = 0;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            idle_inputs();
            if (stall_req) stalls++;
            if (i == delay - 1) begin
                ram_rvalid = 1'b1;
                ram_rdata  = rd;
            end
        end
        @(negedge clk);
        ram_rvalid = 1'b0;
        check({tag, "_stalls"}, DW'(stalls), DW'(delay));
        check({tag, "_stall_rel"}, DW'(stall_req), DW'(0));
        check_write(tag);
    endtask

    initial begin
        int stalls, pulses, d;
        rst        = 1'b0;
        ram_rvalid = 1'b0;
        ram_rdata  = '0;
        idle_inputs();

        #12;
        check("rst_reg_wr_en", DW'(reg_wr_en), DW'(0));
        check("rst_reg_wr_data", reg_wr_data, '0);
        check("rst_stall_req", DW'(stall_req), DW'(0));
        check("rst_hilo", DW'(hilo_wr_en), DW'(0));
        check("rst_cp0", DW'(cp0_wr_en), DW'(0));
        check("rst_timeout", DW'(bus_timeout), DW'(0));
        check_state("rst_state", ST_IDLE);
        @(negedge clk);
        rst = 1'b1;

        // ALU result writes back the next cycle
        @(negedge clk);
        drive_alu(5'd5, 32'h0000_1234);
        @(negedge clk);
        idle_inputs();
        check("alu_stall", DW'(stall_req), DW'(0));
        check_write("alu");

        // HI/LO and CP0 ports
        @(negedge clk);
        hilo_en_in = 1'b1; hi_in = 32'hA5A5_0001; lo_in = 32'h5A5A_0002;
        cp0_en_in = 1'b1; cp0_addr_in = 8'h0C; cp0_data_in = 32'h0000_FF01;
        @(negedge clk);
        idle_inputs();
        check("hilo_en", DW'(hilo_wr_en), DW'(1));
        check("hi", hi_out, 32'hA5A5_0001);
        check("lo", lo_out, 32'h5A5A_0002);
        check("cp0_en", DW'(cp0_wr_en), DW'(1));
        check("cp0_addr", DW'(cp0_wr_addr), DW'(8'h0C));
        check("cp0_data", cp0_wr_data, 32'h0000_FF01);
        check("hilo_no_gpr", DW'(reg_wr_en), DW'(0));

        // LB sign-extended, lane 3, 1-cycle RAM
        @(negedge clk);
        drive_load(5'd7, 32'h0000_1003, MEM_SEL_BYTE, 1'b1);
        exp_q.push_back({5'd7, 32'hFFFF_FF80});
        run_load("lb", 1, 32'h80FF_FF00);

        // LHU lane 2, 3 stall cycles
        @(negedge clk);
        drive_load(5'd9, 32'h0000_2002, MEM_SEL_HALF, 1'b0);
        exp_q.push_back({5'd9, 32'h0000_BEEF});
        run_load("lhu", 3, 32'hBEEF_1234);

        // LBU lane 1, LH lane 0, invalid sel, random latency
        @(negedge clk);
        d = int'($urandom_range(1, 5));
        drive_load(5'd10, 32'h0000_0001, MEM_SEL_BYTE, 1'b0);
        exp_q.push_back({5'd10, 32'h0000_00F6});
        run_load("lbu", d, 32'h1234_F678);
        @(negedge clk);
        d = int'($urandom_range(1, 5));
        drive_load(5'd12, 32'h0000_0100, MEM_SEL_HALF, 1'b1);
        exp_q.push_back({5'd12, 32'hFFFF_8001});
        run_load("lh", d, 32'h1234_8001);
        @(negedge clk);
        drive_load(5'd17, 32'h0000_0000, 4'b0101, 1'b1);
        exp_q.push_back({5'd17, 32'h0000_0000});
        run_load("badsel", 1, 32'hFFFF_FFFF);

        // LW, then stall_in holds the DONE slot
        @(negedge clk);
        drive_load(5'd11, 32'h0000_3000, MEM_SEL_WORD, 1'b0);
        exp_q.push_back({5'd11, 32'hCAFE_BABE});
        run_load("lw", 2, 32'hCAFE_BABE);
        stall_in = 1'b1;
        @(negedge clk);
        check("hold_en", DW'(reg_wr_en), DW'(1));
        check("hold_data", reg_wr_data, 32'hCAFE_BABE);
        check_state("hold_state", ST_DONE);
        stall_in = 1'b0;

        // rvalid while IDLE is ignored
        @(negedge clk);
        ram_rvalid = 1'b1; ram_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        ram_rvalid = 1'b0;
        check_state("idle_rvalid_state", ST_IDLE);
        check("idle_rvalid_stall", DW'(stall_req), DW'(0));
        check("idle_rvalid_wr", DW'(reg_wr_en), DW'(0));

        // flush in WAIT: DRAIN until the stale read returns
        @(negedge clk);
        drive_load(5'd11, 32'h0000_3000, MEM_SEL_WORD, 1'b0);
        @(negedge clk);
        idle_inputs();
        check("fl_wait_stall", DW'(stall_req), DW'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_state("fl_drain_state", ST_DRAIN);
        check("fl_drain_stall", DW'(stall_req), DW'(1));
        check("fl_drain_wr", DW'(reg_wr_en), DW'(0));
        @(negedge clk);
        check("fl_drain_stall2", DW'(stall_req), DW'(1));
        ram_rvalid = 1'b1; ram_rdata = 32'h1111_2222;
        @(negedge clk);
        ram_rvalid = 1'b0;
        check_state("fl_idle_state", ST_IDLE);
        check("fl_idle_stall", DW'(stall_req), DW'(0));
        check("fl_idle_wr", DW'(reg_wr_en), DW'(0));

        // flush coinciding with rvalid goes straight to IDLE
        @(negedge clk);
        drive_load(5'd16, 32'h0000_0000, MEM_SEL_BYTE, 1'b0);
        @(negedge clk);
        idle_inputs();
        flush = 1'b1; ram_rvalid = 1'b1; ram_rdata = 32'h0000_0077;
        @(negedge clk);
        flush = 1'b0; ram_rvalid = 1'b0;
        check_state("flrv_state", ST_IDLE);
        check("flrv_stall", DW'(stall_req), DW'(0));
        check("flrv_wr", DW'(reg_wr_en), DW'(0));

        // excepting instruction is squashed
        @(negedge clk);
        drive_load(5'd3, 32'h0000_0000, MEM_SEL_WORD, 1'b0);
        hilo_en_in = 1'b1; cp0_en_in = 1'b1; exc_null_in = 1'b0;
        @(negedge clk);
        idle_inputs();
        check("exc_wr", DW'(reg_wr_en), DW'(0));
        check("exc_hilo", DW'(hilo_wr_en), DW'(0));
        check("exc_cp0", DW'(cp0_wr_en), DW'(0));
        check_state("exc_state", ST_IDLE);
        check("exc_stall", DW'(stall_req), DW'(0));

        // no rvalid: timeout pulse, GPR written 0
        @(negedge clk);
        drive_load(5'd13, 32'h0000_4000, MEM_SEL_WORD, 1'b0);
        exp_q.push_back({5'd13, 32'h0000_0000});
        stalls = 0;
        pulses = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            idle_inputs();
            if (bus_timeout) begin
                pulses++;
                break;
            end
            if (stall_req) stalls++;
        end
        check("to_pulse", DW'(pulses), DW'(1));
        check("to_stalls", DW'(stalls), DW'(WL + 1));
        check_write("to");
        @(negedge clk);
        check("to_pulse_end", DW'(bus_timeout), DW'(0));
        drive_alu(5'd14, 32'h0000_55AA);
        @(negedge clk);
        idle_inputs();
        check_write("to_resume");

        // asynchronous reset in WAIT
        @(negedge clk);
        drive_load(5'd15, 32'h0000_5000, MEM_SEL_WORD, 1'b0);
        @(negedge clk);
        idle_inputs();
        check("arst_wait_stall", DW'(stall_req), DW'(1));
        #2 rst = 1'b0;
        #1;
        check("arst_stall", DW'(stall_req), DW'(0));
        check_state("arst_state", ST_IDLE);
        check("arst_wr", DW'(reg_wr_en), DW'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_state("arst_after", ST_IDLE);

        check("sb_empty", DW'(exp_q.size()), DW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
